req_agent8: RTL and testbench
=============================

# req_agent8

Requester-side agent for the tree-structured fixed-priority grant selector used in the lab datapath. It collects request pulses from eight clients and keeps a pending-request count per client. It drives `req` and `en` into a combinational priority selector and accepts the one-hot `gnt` that comes back. After accepting a grant, it holds ownership for the winning client for a programmable burst, then re-arbitrates.

## Interface
Parameters:
- `N` — 8 — number of clients; fixed at 8 to match the 8-input selector.
- `CNT_W` — 4 — width of each per-client pending counter; saturates at 2^CNT_W−1.
- `BURST_W` — 3 — width of `burst_len`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clock` input 1 — the only clock; all state updates on its rising edge.
  - `reset` input 1 — asynchronous, active-high; clears all state immediately.
- `new_req` input N — per-client one-cycle request pulse; each set bit adds one pending request for that client.
- `burst_len` input BURST_W — ownership length minus one; sampled on the grant-accept edge.
- `req` output N — request vector to the selector; bit i = (pending_i ≠ 0) while in IDLE, otherwise 0.
- `en` output 1 — enable to the selector; 1 in IDLE, 0 in OWN.
- `gnt` input N — grant vector from the selector; combinational from `req`/`en` in the same cycle.
- `owner` output N — one-hot vector of the current owner; all zeros in IDLE.
- `busy` output 1 — 1 while in OWN.
- `overflow` output N — sticky per client; set when a request is dropped because its counter was saturated.
- `gnt_err` output 1 — sticky; set on any illegal grant.

## Operation
- States:
  - IDLE (the reset state): drives `en`=1 and `req`=pending mask; `owner`=0; `busy`=0.
  - OWN: drives `en`=0 and `req`=0; `owner`=latched grant; `busy`=1.
- IDLE→OWN at a clock edge when `gnt` is exactly one-hot and (`gnt` & `req`) ≠ 0. On that edge:
  - `owner` ← `gnt`.
  - The granted client's pending count decrements by 1.
  - The burst counter loads `burst_len`.
- Illegal grant, evaluated in IDLE:
  - The grant is illegal if `gnt` has more than one bit set, or if it grants a client whose `req` bit is 0.
  - Effect: `gnt_err` ← 1, the grant is ignored, and the block stays in IDLE.
- A grant of all zeros with `req` ≠ 0 is not an error; the block retries the next cycle.
- In OWN: any nonzero `gnt` sets `gnt_err` and is otherwise ignored.
- Burst counter in OWN:
  - Decrements by 1 each cycle.
  - When it is 0, the next edge returns to IDLE with `owner` ← 0.
- Pending counter update, per client per edge: next = count + inc − dec.
  - inc = `new_req[i]`; dec = 1 when this client's grant is accepted.
  - Increment and decrement on the same edge leave the count unchanged.
  - If count is at maximum, inc=1, and dec=0: the count stays at maximum and `overflow[i]` ← 1.
- `new_req` is accepted in every state, including OWN and the grant-accept cycle.
- Sticky flags are cleared only by `reset`.

## Timing
- Reset values: state=IDLE, all counts=0, `req`=0, `en`=1, `owner`=0, `busy`=0, `overflow`=0, `gnt_err`=0, burst counter=0.
- Reset is asynchronous: asserting it mid-burst returns all outputs to their reset values without waiting for a clock edge. Pending counts are lost.
- Request latency: a `new_req[i]` pulse at edge k makes `req[i]`=1 in cycle k+1, provided the block is in IDLE.
- Burst timing, with the grant accepted at edge k:
  - `owner`/`busy` are valid from cycle k+1 through cycle k+1+`burst_len`, i.e. `burst_len`+1 cycles.
  - `en`=1 again in cycle k+2+`burst_len`.
- Back-to-back grants are spaced `burst_len`+2 cycles apart, since one IDLE cycle is needed per arbitration.
- Because `gnt` is combinational, `req`/`en` must be driven straight from registered state (no combinational path from `gnt` to `req`/`en`), so the loop cannot close within a cycle.

## Test plan
- **Reset state:** assert `reset` → `en`=1, `req`=0, `owner`=0, `busy`=0, `overflow`=0, `gnt_err`=0.
- **Single grant:** pulse `new_req`=8'h04 with `burst_len`=2, and model the selector in the bench.
  - `req`=8'h04 the next cycle; the grant is accepted.
  - `owner`=8'h04 for exactly 3 cycles; then `en`=1, `req`=0.
- **Priority and re-arbitration:** pulse `new_req`=8'h81 twice, with `burst_len`=0.
  - Grant order 8'h80, 8'h80, 8'h01, 8'h01, each owning 1 cycle.
  - Arbitrations are 2 cycles apart, and `req` goes to 0 after the fourth.
- **Saturation:** pulse `new_req[3]` 16 times with `CNT_W`=4 and no grants.
  - The count stays at 15 and `overflow`=8'h08.
  - A simultaneous inc/dec at count 15 leaves the count at 15 with no new overflow.
- **Illegal grant:**
  - Drive `gnt`=8'h06 in IDLE → `gnt_err`=1, state stays IDLE, counts unchanged.
  - Drive `gnt`=8'h01 during OWN → `gnt_err` stays 1 and `owner` is unchanged.
- **Reset mid-burst:** assert `reset` asynchronously at cycle 2 of a 5-cycle burst → `busy`=0 and `owner`=0 before the next edge; all counts=0 after release.

Source files
------------

// File: rtl/req_agent8_if.sv
// Handshake bundle between the requester agent and the fixed-priority selector.
// master: the agent side; slave: clients plus the combinational selector.
interface req_agent8_if #(
  parameter int N       = 8,
  parameter int BURST_W = 3
);
  logic [N-1:0]       new_req;
  logic [BURST_W-1:0] burst_len;
  logic [N-1:0]       req;
  logic               en;
  logic [N-1:0]       gnt;
  logic [N-1:0]       owner;
  logic               busy;
  logic [N-1:0]       overflow;
  logic               gnt_err;

  modport master (
    input  new_req, burst_len, gnt,
    output req, en, owner, busy, overflow, gnt_err
  );

  modport slave (
    output new_req, burst_len, gnt,
    input  req, en, owner, busy, overflow, gnt_err
  );
endinterface

// File: rtl/req_agent8.sv
// Requester agent: per-client pending counters, grant acceptance from an external
// combinational priority selector, and burst ownership before re-arbitration.
module req_agent8 #(
  parameter int N       = 8,
  parameter int CNT_W   = 4,
  parameter int BURST_W = 3
) (
  input  logic         clock,
  input  logic         reset,
  req_agent8_if.master bus
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [N-1:0]     ONE_N   = N'(1);

  state_t             state_q, state_d;
  logic [N-1:0]       owner_q, owner_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [N-1:0]       ovf_q, ovf_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q [N];
  logic [CNT_W-1:0]   cnt_d [N];

  logic [N-1:0]       pend_mask;
  logic               gnt_any;
  logic               gnt_onehot;
  logic               accept;

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pend_mask[i] = (cnt_q[i] != '0);
    end
  end

  // req/en come only from registered state so the selector loop never closes combinationally.
  assign bus.req      = (state_q == IDLE) ? pend_mask : '0;
  assign bus.en       = (state_q == IDLE);
  assign bus.owner    = owner_q;
  assign bus.busy     = (state_q == OWN);
  assign bus.overflow = ovf_q;
  assign bus.gnt_err  = err_q;

  assign gnt_any    = (bus.gnt != '0);
  assign gnt_onehot = gnt_any && ((bus.gnt & (bus.gnt - ONE_N)) == '0);
  assign accept     = (state_q == IDLE) && gnt_onehot && ((bus.gnt & pend_mask) != '0);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = OWN;
          owner_d = bus.gnt;
          burst_d = bus.burst_len;
        end else if (gnt_any) begin
          err_d = 1'b1;
        end
      end
      OWN: begin
        if (gnt_any) begin
          err_d = 1'b1;
        end
        if (burst_q == '0) begin
          state_d = IDLE;
          owner_d = '0;
        end else begin
          burst_d = burst_q - BURST_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  // Simultaneous inc/dec cancels; a saturated counter drops the increment and flags it.
  always_comb begin
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.new_req[i] && !(accept && bus.gnt[i])) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (!bus.new_req[i] && accept && bus.gnt[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      burst_q <= '0;
      ovf_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_req_agent8.sv
// Scoreboard bench for req_agent8: a count-based reference model predicts grants and
// outputs; a monitor pops predicted bursts and checks owner and burst length.
module tb_req_agent8;

  localparam int CMAX = 15;

  logic clock;
  logic reset;
  bit   force_en;
  logic [7:0] force_val;

  req_agent8_if #(.N(8), .BURST_W(3)) ifc ();

  req_agent8 #(.N(8), .CNT_W(4), .BURST_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [7:0] prio(input logic [7:0] r);
    logic [7:0] g;
    g = '0;
    for (int i = 0; i < 8; i++) begin
      if (r[i]) g = 8'(1) << i;
    end
    return g;
  endfunction

  // Selector: highest index wins; the bench can override it to inject illegal grants.
  always_comb begin
    if (force_en)    ifc.gnt = force_val;
    else if (ifc.en) ifc.gnt = prio(ifc.req);
    else             ifc.gnt = '0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] owner;
    int         len;
  } exp_t;
  exp_t expq[$];

  int         cnt_m [8];
  bit         m_own;
  int         m_left;
  logic [7:0] m_owner;
  logic [7:0] m_ovf;
  bit         m_err;

  function automatic logic [7:0] model_mask();
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i] = (cnt_m[i] != 0);
    return m;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) cnt_m[i] = 0;
    m_own = 0; m_left = 0; m_owner = '0; m_ovf = '0; m_err = 0;
    expq.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_en",       32'(ifc.en),       32'(1));
    chk("rst_req",      32'(ifc.req),      32'(0));
    chk("rst_owner",    32'(ifc.owner),    32'(0));
    chk("rst_busy",     32'(ifc.busy),     32'(0));
    chk("rst_overflow", 32'(ifc.overflow), 32'(0));
    chk("rst_gnt_err",  32'(ifc.gnt_err),  32'(0));
    model_clear();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One cycle: drive inputs after the falling edge, check outputs, advance the model.
  task automatic step(input logic [7:0] nr, input logic [2:0] bl, input bit fe, input logic [7:0] fv);
    logic [7:0] mreq, g;
    bit acc;
    ifc.new_req = nr; ifc.burst_len = bl; force_en = fe; force_val = fv;
    #1;
    mreq = m_own ? 8'h00 : model_mask();
    chk("req",      32'(ifc.req),      32'(mreq));
    chk("en",       32'(ifc.en),       32'(!m_own));
    chk("busy",     32'(ifc.busy),     32'(m_own));
    chk("owner",    32'(ifc.owner),    32'(m_owner));
    chk("overflow", 32'(ifc.overflow), 32'(m_ovf));
    chk("gnt_err",  32'(ifc.gnt_err),  32'(m_err));
    g   = fe ? fv : (m_own ? 8'h00 : prio(mreq));
    acc = !m_own && ($countones(g) == 1) && ((g & mreq) != 0);
    if (g != 0 && !acc) m_err = 1;
    for (int i = 0; i < 8; i++) begin
      int n;
      n = cnt_m[i] + int'(nr[i]) - int'(acc && g[i]);
      if (n > CMAX) begin
        n = CMAX;
        m_ovf[i] = 1'b1;
      end
      cnt_m[i] = n;
    end
    if (acc) begin
      expq.push_back('{owner: g, len: int'(bl) + 1});
      m_own = 1; m_owner = g; m_left = int'(bl) + 1;
    end else if (m_own) begin
      m_left--;
      if (m_left == 0) begin
        m_own = 0; m_owner = '0;
      end
    end
    @(negedge clock);
  endtask

  bit         prev_busy;
  int         run_len;
  int         exp_len;
  logic [7:0] exp_owner;

  always @(negedge clock or posedge reset) begin
    if (reset) begin
      prev_busy = 0;
      run_len   = 0;
    end else begin
      #2;
      if (ifc.busy && !prev_busy) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_grant: owner %0h with no grant predicted at %0t", ifc.owner, $time);
          exp_owner = 'x;
          exp_len   = -1;
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("grant_owner", 32'(ifc.owner), 32'(e.owner));
          exp_owner = e.owner;
          exp_len   = e.len;
        end
        run_len = 1;
      end else if (ifc.busy) begin
        run_len++;
        chk("owner_hold", 32'(ifc.owner), 32'(exp_owner));
      end else if (prev_busy) begin
        chk("burst_len", 32'(run_len), 32'(exp_len));
      end
      prev_busy = ifc.busy;
    end
  end

  initial begin
    reset = 1'b1;
    force_en = 0; force_val = '0;
    ifc.new_req = '0; ifc.burst_len = '0;
    model_clear();
    @(negedge clock);
    apply_reset();

    // single grant, burst of 3
    step(8'h04, 3'd2, 0, 8'h00);
    repeat (6) step(8'h00, 3'd2, 0, 8'h00);

    // priority and re-arbitration
    step(8'h81, 3'd0, 0, 8'h00);
    step(8'h81, 3'd0, 0, 8'h00);
    repeat (10) step(8'h00, 3'd0, 0, 8'h00);

    // saturation with grants held off, then simultaneous inc/dec at max
    repeat (16) step(8'h08, 3'd0, 1, 8'h00);
    step(8'h00, 3'd0, 1, 8'h00);
    step(8'h08, 3'd0, 0, 8'h00);
    repeat (40) step(8'h00, 3'd0, 0, 8'h00);

    // illegal grants in IDLE and in OWN
    step(8'h06, 3'd3, 1, 8'h00);
    step(8'h00, 3'd3, 1, 8'h06);
    step(8'h00, 3'd3, 1, 8'h00);
    step(8'h00, 3'd3, 0, 8'h00);
    step(8'h00, 3'd3, 1, 8'h01);
    repeat (12) step(8'h00, 3'd3, 0, 8'h00);

    // reset in the middle of a 5-cycle burst
    apply_reset();
    step(8'h21, 3'd4, 0, 8'h00);
    step(8'h10, 3'd4, 0, 8'h00);
    step(8'h00, 3'd4, 0, 8'h00);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_busy",  32'(ifc.busy),  32'(0));
    chk("midrst_owner", 32'(ifc.owner), 32'(0));
    chk("midrst_en",    32'(ifc.en),    32'(1));
    model_clear();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) step(8'h00, 3'd1, 0, 8'h00);

    // randomized traffic with occasional forced grants
    for (int k = 0; k < 400; k++) begin
      logic [7:0] nr, fv;
      bit fe;
      nr = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      fe = ($urandom_range(0, 40) == 0);
      fv = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      step(nr, 3'($urandom_range(0, 7)), fe, fv);
    end

    // drain, bounded
    for (int k = 0; k < 2000; k++) begin
      if (!m_own && model_mask() == 8'h00) break;
      step(8'h00, 3'($urandom_range(0, 7)), 0, 8'h00);
    end
    repeat (3) step(8'h00, 3'd0, 0, 8'h00);
    chk("queue_drained", 32'(expq.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
